pipe_muxn: RTL
==============

Name: pipe_muxn

Overview:
Parametrised N:1 data selector with a registered, flow-controlled output stage: the pipelined successor of the team's fixed 4-input combinational selector. Used in the pipeline datapath wherever a selected operand (forwarding, writeback source, PC source) must cross a stage boundary with valid/ready backpressure. The selection, registering and 2-entry skid buffering all happen in one block, so stalls never drop or duplicate a selected word.

Parameters:
WIDTH, 32, data width of each input and of the output
NUM_IN, 4, number of data inputs (2..16)
SEL_W, $clog2(NUM_IN), select width; derived, never overridden
DEFAULT_VAL, 0, value output when select is out of range (sel >= NUM_IN)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_data  in  NUM_IN*WIDTH  packed inputs; input k = in_data[k*WIDTH +: WIDTH]
in_sel  in  SEL_W  selects the input to capture
in_valid  in  1  upstream word/select valid
in_ready  out  1  block can accept this cycle
out_data  out  WIDTH  selected word, registered
out_sel  out  SEL_W  select value that produced out_data
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts
flush  in  1  synchronous discard of all held entries
sel_err  out  1  sticky: an out-of-range select was accepted
err_clr  in  1  clears sel_err

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_data=0, out_sel=0, sel_err=0, skid empty, in_ready=1 once reset releases. Reset mid-transfer discards all held data.
- Accept: acc = in_valid & in_ready. Capture = selected input (or DEFAULT_VAL if in_sel >= NUM_IN), plus in_sel.
- Release: rel = out_valid & out_ready.
- Latency: accept at cycle n -> out_valid=1 with that data at cycle n+1. No combinational path from in_* to out_*.
- in_ready = !skid_full, driven from a register. It does not depend on out_ready combinationally.
- States (occupancy):
  - EMPTY: acc -> ONE (main loaded).
  - ONE: acc&rel -> ONE (main reloaded). acc&!rel -> TWO (new word to skid). !acc&rel -> EMPTY. Neither -> hold.
  - TWO: in_ready=0. rel -> ONE (skid moves to main). Otherwise hold.
- Ordering: strict FIFO. Data and out_sel stay stable while out_valid=1 and out_ready=0.
- flush=1: next cycle is EMPTY, out_valid=0, in_ready=1. Flush beats a simultaneous accept; the word offered that cycle is dropped and sel_err is not set by it. Flush does not clear sel_err.
- sel_err: set on an accept with in_sel >= NUM_IN. Cleared by err_clr. If set and clear occur in the same cycle, set wins. When NUM_IN is a power of two it can never set.
- out_data holds its last value when out_valid=0 (no zeroing except at reset).

Test Plan:
- Reset/basic: in_data inputs {0..3}={0x11,0x22,0x33,0x44}, in_sel=2, in_valid=1, out_ready=1 for one cycle -> next cycle out_valid=1, out_data=0x33, out_sel=2. During rst_n=0, all outputs are 0.
- Backpressure: hold out_ready=0 and send 3 words with sel=0,1,3 -> first two accepted. in_ready drops after the 2nd. Release out_ready -> outputs are 0x11 then 0x22 then 0x44 in order, with no loss or duplication.
- Full throughput: in_valid=out_ready=1 for 100 cycles with random sel -> one output per cycle, in_ready is never 0, and the output stream equals the input stream delayed by 1.
- Out-of-range (NUM_IN=5, SEL_W=3): accept in_sel=6 -> out_data=DEFAULT_VAL, sel_err=1 and stays 1. err_clr together with another bad accept -> sel_err stays 1. err_clr alone -> 0.
- Flush: state TWO, then flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the offered word never appears. sel_err is unchanged.
- Async reset mid-stall: state TWO, rst_n pulsed low between clock edges -> out_valid=0 immediately. After release, in_ready=1 and the old words never appear.

Source files
------------

// File: rtl/pipe_muxn.sv
// N:1 data selector with a registered valid/ready output stage and a 2-entry skid buffer.
// A selected word and the select value that produced it travel together in strict FIFO order.
`timescale 1ns/1ps

module pipe_muxn #(
   parameter int unsigned      WIDTH       = 32,
   parameter int unsigned      NUM_IN      = 4,
   parameter logic [WIDTH-1:0] DEFAULT_VAL = '0,
   parameter int unsigned      SEL_W       = $clog2(NUM_IN)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic [SEL_W-1:0]        in_sel,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic [SEL_W-1:0]        out_sel,
   output logic                    out_valid,
   input  logic                    out_ready,
   input  logic                    flush,
   output logic                    sel_err,
   input  logic                    err_clr
);

   typedef enum logic [1:0] {
      ST_EMPTY,
      ST_ONE,
      ST_TWO
   } occ_e;

   occ_e             state_q, state_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic             sel_err_q, sel_err_d;
   logic [WIDTH-1:0] main_data_q, main_data_d;
   logic [SEL_W-1:0] main_sel_q, main_sel_d;
   logic [WIDTH-1:0] skid_data_q, skid_data_d;
   logic [SEL_W-1:0] skid_sel_q, skid_sel_d;

   logic [WIDTH-1:0] cap_data;
   logic             sel_bad;
   logic             acc;
   logic             rel;

   // NOTE: every signal written in an always_comb block gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      cap_data = DEFAULT_VAL;
      sel_bad  = 1'b1;
      for (int k = 0; k < NUM_IN; k++) begin
         if (in_sel == SEL_W'(k)) begin
            cap_data = in_data[k*WIDTH +: WIDTH];
            sel_bad  = 1'b0;
         end
      end
   end

   assign acc = in_valid & in_ready_q;
   assign rel = out_valid_q & out_ready;

   always_comb begin
      state_d     = state_q;
      main_data_d = main_data_q;
      main_sel_d  = main_sel_q;
      skid_data_d = skid_data_q;
      skid_sel_d  = skid_sel_q;
      sel_err_d   = sel_err_q;

      unique case (state_q)
         ST_EMPTY: begin
            if (acc) begin
               main_data_d = cap_data;
               main_sel_d  = in_sel;
               state_d     = ST_ONE;
            end
         end
         ST_ONE: begin
            if (acc && rel) begin
               main_data_d = cap_data;
               main_sel_d  = in_sel;
            end else if (acc) begin
               skid_data_d = cap_data;
               skid_sel_d  = in_sel;
               state_d     = ST_TWO;
            end else if (rel) begin
               state_d = ST_EMPTY;
            end
         end
         ST_TWO: begin
            if (rel) begin
               main_data_d = skid_data_q;
               main_sel_d  = skid_sel_q;
               state_d     = ST_ONE;
            end
         end
         default: state_d = ST_EMPTY;
      endcase

      // Flush drops everything held or offered; the visible word stays frozen.
      if (flush) begin
         state_d     = ST_EMPTY;
         main_data_d = main_data_q;
         main_sel_d  = main_sel_q;
      end

      if (err_clr) sel_err_d = 1'b0;
      if (acc && sel_bad && !flush) sel_err_d = 1'b1;
   end

   assign in_ready_d  = (state_d != ST_TWO);
   assign out_valid_d = (state_d != ST_EMPTY);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_EMPTY;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         sel_err_q   <= 1'b0;
         main_data_q <= '0;
         main_sel_q  <= '0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         sel_err_q   <= sel_err_d;
         main_data_q <= main_data_d;
         main_sel_q  <= main_sel_d;
      end
   end

   // NOTE: the skid entry is storage only; it is never observed before being written, so it carries no reset.
   always_ff @(posedge clk) begin
      skid_data_q <= skid_data_d;
      skid_sel_q  <= skid_sel_d;
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = main_data_q;
   assign out_sel   = main_sel_q;
   assign sel_err   = sel_err_q;

endmodule
